// File: rtl/hack_pkg.sv
// Shared types and default widths for the Hack boot sequencer and CPU glue.
package hack_pkg;

  localparam int HACK_DATA_WIDTH    = 16;
  localparam int HACK_ADDRESS_WIDTH = 16;
  localparam int HACK_ROM_DEPTH     = 64;
  localparam int HACK_RST_CYCLES    = 2;
  localparam int HACK_HALT_REPEAT   = 4;
  localparam int HACK_CYCLE_WIDTH   = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_HALTED  = 3'd4,
    ST_ERROR   = 3'd5
  } boot_state_t;

  // States in which the sequencer owns the CPU and the instruction RAM.
  function automatic logic state_is_busy(input boot_state_t s);
    return (s == ST_LOAD) || (s == ST_RELEASE) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/hack_halt_detect.sv
// End-of-program detector: watches the CPU program counter while running and
// flags a halt once the PC repeats with period 1 or 2 for HALT_REPEAT cycles.
module hack_halt_detect #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int HALT_REPEAT   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     run_i,
  input  logic [ADDRESS_WIDTH-1:0] pc_i,
  output logic                     halt_o
);

  localparam int MW = $clog2(HALT_REPEAT + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(HALT_REPEAT);

  logic [ADDRESS_WIDTH-1:0] pc_d1_q, pc_d2_q;
  logic [1:0]               hist_q;
  logic [MW-1:0]            match_q, match_d;

  // Comparing against the PC two samples back catches both "jmp self" and
  // a two-instruction "@x; 0;JMP" loop with a single comparator.
  always_comb begin
    match_d = match_q;
    if (hist_q == 2'd2) begin
      if (pc_i == pc_d2_q) begin
        match_d = (match_q == MATCH_MAX) ? match_q : match_q + MW'(1);
      end else begin
        match_d = '0;
      end
    end
    halt_o = run_i && (match_d == MATCH_MAX);
  end

  // PC history and match count live only while running; anything else wipes them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_d1_q <= '0;
      pc_d2_q <= '0;
      hist_q  <= 2'd0;
      match_q <= '0;
    end else if (!run_i) begin
      pc_d1_q <= '0;
      pc_d2_q <= '0;
      hist_q  <= 2'd0;
      match_q <= '0;
    end else begin
      pc_d2_q <= pc_d1_q;
      pc_d1_q <= pc_i;
      if (hist_q != 2'd2) hist_q <= hist_q + 2'd1;
      match_q <= match_d;
    end
  end

endmodule

// File: rtl/hack_boot_ctrl.sv
// Boot and run sequencer for the Hack CPU: loads a program from a stream into
// instruction RAM, releases the CPU from reset, and freezes it at the final loop.
//
// Load stream handshake: a word transfers on a rising edge where load_valid_i
// and load_ready_o are both high. load_ready_o depends only on state (never on
// load_valid_i); the source must hold data/last stable while valid is high
// and not yet accepted.
module hack_boot_ctrl
  import hack_pkg::*;
#(
  parameter int DATA_WIDTH    = HACK_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = HACK_ADDRESS_WIDTH,
  parameter int ROM_DEPTH     = HACK_ROM_DEPTH,
  parameter int RST_CYCLES    = HACK_RST_CYCLES,
  parameter int HALT_REPEAT   = HACK_HALT_REPEAT,
  parameter int CYCLE_WIDTH   = HACK_CYCLE_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     load_valid_i,
  output logic                     load_ready_o,
  input  logic [DATA_WIDTH-1:0]    load_data_i,
  input  logic                     load_last_i,
  output logic                     rom_we_o,
  output logic [ADDRESS_WIDTH-1:0] rom_addr_o,
  output logic [DATA_WIDTH-1:0]    rom_wdata_o,
  output logic                     cpu_rst_o,
  input  logic [ADDRESS_WIDTH-1:0] cpu_pc_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [ADDRESS_WIDTH-1:0] word_count_o,
  output logic [CYCLE_WIDTH-1:0]   run_cycles_o,
  output boot_state_t              state_o
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]            REL_LAST = RW'(RST_CYCLES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(ROM_DEPTH - 1);

  boot_state_t              state_q;
  logic                     rom_we_q;
  logic [ADDRESS_WIDTH-1:0] rom_addr_q;
  logic [DATA_WIDTH-1:0]    rom_wdata_q;
  logic                     cpu_rst_q;
  logic [ADDRESS_WIDTH-1:0] word_count_q;
  logic [CYCLE_WIDTH-1:0]   run_cycles_q;
  logic [RW-1:0]            rel_cnt_q;

  logic                     hs;
  logic                     halt;
  logic [CYCLE_WIDTH-1:0]   run_cycles_inc;

  assign load_ready_o = (state_q == ST_LOAD);
  assign busy_o       = state_is_busy(state_q);
  assign done_o       = (state_q == ST_HALTED);
  assign error_o      = (state_q == ST_ERROR);
  assign state_o      = state_q;
  assign rom_we_o     = rom_we_q;
  assign rom_addr_o   = rom_addr_q;
  assign rom_wdata_o  = rom_wdata_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign word_count_o = word_count_q;
  assign run_cycles_o = run_cycles_q;

  assign hs = load_valid_i && load_ready_o;
  assign run_cycles_inc = (&run_cycles_q) ? run_cycles_q : run_cycles_q + CYCLE_WIDTH'(1);

  hack_halt_detect #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .HALT_REPEAT   (HALT_REPEAT)
  ) u_halt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .run_i  (state_q == ST_RUN),
    .pc_i   (cpu_pc_i),
    .halt_o (halt)
  );

  // Sequencer FSM plus all registered outputs. An accepted word is always
  // written one cycle later, even if abort arrives on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      rom_we_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_wdata_q  <= '0;
      cpu_rst_q    <= 1'b1;
      word_count_q <= '0;
      run_cycles_q <= '0;
      rel_cnt_q    <= '0;
    end else begin
      rom_we_q <= 1'b0;
      if (hs) begin
        rom_we_q     <= 1'b1;
        rom_addr_q   <= word_count_q;
        rom_wdata_q  <= load_data_i;
        word_count_q <= word_count_q + ADDRESS_WIDTH'(1);
      end

      if (abort_i) begin
        state_q   <= ST_IDLE;
        cpu_rst_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE, ST_HALTED, ST_ERROR: begin
            if (start_i) begin
              state_q      <= ST_LOAD;
              word_count_q <= '0;
              run_cycles_q <= '0;
              cpu_rst_q    <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (hs) begin
              if (load_last_i) begin
                state_q   <= ST_RELEASE;
                rel_cnt_q <= '0;
              end else if (word_count_q == LAST_IDX) begin
                state_q <= ST_ERROR;
              end
            end
          end
          ST_RELEASE: begin
            if (rel_cnt_q == REL_LAST) begin
              state_q      <= ST_RUN;
              cpu_rst_q    <= 1'b0;
              run_cycles_q <= run_cycles_inc;
            end else begin
              rel_cnt_q <= rel_cnt_q + RW'(1);
            end
          end
          ST_RUN: begin
            if (halt) begin
              state_q   <= ST_HALTED;
              cpu_rst_q <= 1'b1;
            end else begin
              run_cycles_q <= run_cycles_inc;
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            cpu_rst_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Bench for hack_boot_ctrl: a cycle table for the reference boot/run/halt flow,
// directed corner sequences, and randomized programs and PC traces.
module tb_hack_boot_ctrl;
  import hack_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int CW = 32;
  localparam int RST_CYCLES  = 2;
  localparam int HALT_REPEAT = 4;

  // ---------------- clock / reset ----------------
  logic clk, rst_ni;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          start_i, abort_i, load_valid_i, load_last_i;
  logic [DW-1:0] load_data_i;
  logic [AW-1:0] cpu_pc_i;
  logic          load_ready_o, rom_we_o, cpu_rst_o, busy_o, done_o, error_o;
  logic [AW-1:0] rom_addr_o, word_count_o;
  logic [DW-1:0] rom_wdata_o;
  logic [CW-1:0] run_cycles_o;
  boot_state_t   state_o;

  hack_boot_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
    .load_data_i(load_data_i), .load_last_i(load_last_i),
    .rom_we_o(rom_we_o), .rom_addr_o(rom_addr_o), .rom_wdata_o(rom_wdata_o),
    .cpu_rst_o(cpu_rst_o), .cpu_pc_i(cpu_pc_i), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .word_count_o(word_count_o),
    .run_cycles_o(run_cycles_o), .state_o(state_o)
  );

  int          checks, errors;
  logic [31:0] cyc;
  logic [63:0] exp_q[$];   // {cycle the write must appear, addr, data}
  logic [63:0] mon_e;
  logic [15:0] prog[64];
  int          pc_arr[64];

  always @(posedge clk) cyc <= cyc + 32'd1;

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Write port monitor: every strobe must match the oldest expected write
  // in address, data and cycle; an expected write that never shows is missed.
  always @(negedge clk) begin
    if (rom_we_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rom_write: unexpected write addr %0h data %0h at cycle %0d, want none",
                 rom_addr_o, rom_wdata_o, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[63:32] !== cyc || mon_e[31:16] !== rom_addr_o || mon_e[15:0] !== rom_wdata_o) begin
          errors++;
          $display("FAIL rom_write: got cyc %0d addr %0h data %0h, want cyc %0d addr %0h data %0h",
                   cyc, rom_addr_o, rom_wdata_o, mon_e[63:32], mon_e[31:16], mon_e[15:0]);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0][63:32] <= cyc) begin
      checks++;
      errors++;
      mon_e = exp_q.pop_front();
      $display("FAIL rom_write: no write at cycle %0d, want addr %0h data %0h",
               cyc, mon_e[31:16], mon_e[15:0]);
    end
  end

  // ---------------- reference model ----------------
  // Halt happens on the RUN cycle (1-based) where the PC has equalled the
  // PC two cycles earlier for HALT_REPEAT consecutive cycles.
  function automatic int model_halt(input int len);
    int run = 0;
    for (int k = 2; k < len; k++) begin
      if (pc_arr[k] == pc_arr[k-2]) run++;
      else run = 0;
      if (run == HALT_REPEAT) return k + 1;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_state", state_o, ST_LOAD);
    chk("start_word_count", word_count_o, 0);
    chk("start_run_cycles", run_cycles_o, 0);
  endtask

  // gap_kind: 0 = valid held, 1 = one idle cycle before each word, 2 = random idles
  task automatic load_prog(input int n, input bit with_last, input int gap_kind);
    for (int i = 0; i < n; i++) begin
      int gaps;
      gaps = (gap_kind == 1) ? 1 : (gap_kind == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        load_valid_i = 1'b0;
        load_data_i  = 16'($urandom);
        load_last_i  = 1'($urandom);
        chk("gap_ready", load_ready_o, 1);
        tick();
      end
      load_valid_i = 1'b1;
      load_data_i  = prog[i];
      load_last_i  = with_last && (i == n - 1);
      chk("load_ready", load_ready_o, 1);
      chk("load_word_count", word_count_o, i);
      exp_q.push_back({cyc + 32'd1, 16'(i), prog[i]});
      tick();
    end
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
  endtask

  task automatic run_and_halt(input int exp_h, input int exp_wc);
    for (int r = 0; r < RST_CYCLES; r++) begin
      chk("rel_state", state_o, ST_RELEASE);
      chk("rel_cpu_rst", cpu_rst_o, 1);
      chk("rel_word_count", word_count_o, exp_wc);
      tick();
    end
    for (int k = 0; k < exp_h && k < 64; k++) begin
      cpu_pc_i = 16'(pc_arr[k]);
      chk("run_state", state_o, ST_RUN);
      chk("run_cpu_rst", cpu_rst_o, 0);
      chk("run_cycles", run_cycles_o, k + 1);
      tick();
    end
    chk("halt_done", done_o, 1);
    chk("halt_cpu_rst", cpu_rst_o, 1);
    chk("halt_busy", busy_o, 0);
    chk("halt_run_cycles", run_cycles_o, exp_h);
    chk("halt_word_count", word_count_o, exp_wc);
    cpu_pc_i = '0;
  endtask

  // ---------------- reference cycle table ----------------
  typedef struct {
    logic        start, abort, valid, last;
    logic [15:0] data, pc;
    boot_state_t est;
    logic        er, eb, ed, ee, ecr;
    logic [15:0] ewc;
    logic [31:0] erc;
  } vec_t;

  vec_t vecs[22];
  int   tpc[10] = '{0, 1, 2, 3, 4, 5, 4, 5, 4, 5};

  function automatic vec_t mk(input logic s, a, v, l, input logic [15:0] d, p,
                              input boot_state_t st, input logic r, b, dn, e, cr,
                              input logic [15:0] wc, input logic [31:0] rc);
    vec_t x;
    x.start = s; x.abort = a; x.valid = v; x.last = l; x.data = d; x.pc = p;
    x.est = st; x.er = r; x.eb = b; x.ed = dn; x.ee = e; x.ecr = cr;
    x.ewc = wc; x.erc = rc;
    return x;
  endfunction

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_ni = 1'b0; start_i = 0; abort_i = 0; load_valid_i = 0; load_last_i = 0;
    load_data_i = '0; cpu_pc_i = '0;

    vecs[0] = mk(1, 0, 0, 0, 16'h0000, 0, ST_IDLE,    0, 0, 0, 0, 1, 0, 0);
    vecs[1] = mk(0, 0, 1, 0, 16'h0002, 0, ST_LOAD,    1, 1, 0, 0, 1, 0, 0);
    vecs[2] = mk(0, 0, 1, 0, 16'hEC10, 0, ST_LOAD,    1, 1, 0, 0, 1, 1, 0);
    vecs[3] = mk(0, 0, 1, 0, 16'h0003, 0, ST_LOAD,    1, 1, 0, 0, 1, 2, 0);
    vecs[4] = mk(0, 0, 1, 0, 16'hE088, 0, ST_LOAD,    1, 1, 0, 0, 1, 3, 0);
    vecs[5] = mk(0, 0, 1, 0, 16'h0000, 0, ST_LOAD,    1, 1, 0, 0, 1, 4, 0);
    vecs[6] = mk(0, 0, 1, 1, 16'hE310, 0, ST_LOAD,    1, 1, 0, 0, 1, 5, 0);
    vecs[7] = mk(1, 0, 0, 0, 16'h0000, 0, ST_RELEASE, 0, 1, 0, 0, 1, 6, 0);
    vecs[8] = mk(0, 0, 0, 0, 16'h0000, 0, ST_RELEASE, 0, 1, 0, 0, 1, 6, 0);
    for (int k = 0; k < 10; k++)
      vecs[9+k] = mk(k == 3, 0, 0, 0, 16'h0000, 16'(tpc[k]), ST_RUN, 0, 1, 0, 0, 0, 6, k + 1);
    vecs[19] = mk(1, 0, 0, 0, 16'h0000, 0, ST_HALTED, 0, 0, 1, 0, 1, 6, 10);
    vecs[20] = mk(1, 1, 0, 0, 16'h0000, 0, ST_LOAD,   1, 1, 0, 0, 1, 0, 0);
    vecs[21] = mk(0, 0, 0, 0, 16'h0000, 0, ST_IDLE,   0, 0, 0, 0, 1, 0, 0);

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_rst", cpu_rst_o, 1);
    chk("rst_rom_we", rom_we_o, 0);
    chk("rst_rom_addr", rom_addr_o, 0);
    chk("rst_rom_wdata", rom_wdata_o, 0);
    chk("rst_run_cycles", run_cycles_o, 0);
    rst_ni = 1'b1;

    // table: 6-word program, release timing, 2-word end loop, halt, abort beats start
    for (int i = 0; i < 22; i++) begin
      start_i = vecs[i].start; abort_i = vecs[i].abort;
      load_valid_i = vecs[i].valid; load_last_i = vecs[i].last;
      load_data_i = vecs[i].data; cpu_pc_i = vecs[i].pc;
      chk($sformatf("vec%0d_state", i), state_o, vecs[i].est);
      chk($sformatf("vec%0d_ready", i), load_ready_o, vecs[i].er);
      chk($sformatf("vec%0d_busy", i), busy_o, vecs[i].eb);
      chk($sformatf("vec%0d_done", i), done_o, vecs[i].ed);
      chk($sformatf("vec%0d_error", i), error_o, vecs[i].ee);
      chk($sformatf("vec%0d_cpu_rst", i), cpu_rst_o, vecs[i].ecr);
      chk($sformatf("vec%0d_word_count", i), word_count_o, vecs[i].ewc);
      chk($sformatf("vec%0d_run_cycles", i), run_cycles_o, vecs[i].erc);
      if (vecs[i].valid && vecs[i].er) exp_q.push_back({cyc + 32'd1, vecs[i].ewc, vecs[i].data});
      tick();
    end
    start_i = 0; abort_i = 0; load_valid_i = 0; load_last_i = 0; cpu_pc_i = '0;

    // valid toggling every other cycle, then a 1-instruction end loop
    for (int i = 0; i < 8; i++) prog[i] = 16'($urandom);
    for (int i = 0; i < 16; i++) pc_arr[i] = 7;
    start_load();
    load_prog(8, 1'b1, 1);
    run_and_halt(model_halt(16), 8);
    chk("loop1_halt_at", model_halt(16), 6);

    // 64 words without last -> ERROR, then restart
    for (int i = 0; i < 64; i++) prog[i] = 16'($urandom);
    start_load();
    load_prog(64, 1'b0, 0);
    chk("ovf_error", error_o, 1);
    chk("ovf_ready", load_ready_o, 0);
    chk("ovf_state", state_o, ST_ERROR);
    chk("ovf_word_count", word_count_o, 64);
    chk("ovf_cpu_rst", cpu_rst_o, 1);
    tick();
    chk("ovf_hold_error", error_o, 1);
    start_load();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_load_state", state_o, ST_IDLE);

    // abort together with start in RUN at run_cycles == 10
    prog[0] = 16'h1234; prog[1] = 16'hABCD;
    start_load();
    load_prog(2, 1'b1, 0);
    repeat (RST_CYCLES) tick();
    for (int k = 0; k < 10; k++) begin
      cpu_pc_i = 16'(k * 3);
      chk("abrun_run_cycles", run_cycles_o, k + 1);
      chk("abrun_cpu_rst", cpu_rst_o, 0);
      if (k == 9) begin
        abort_i = 1'b1;
        start_i = 1'b1;
      end
      tick();
    end
    abort_i = 1'b0; start_i = 1'b0;
    chk("abrun_state", state_o, ST_IDLE);
    chk("abrun_cpu_rst", cpu_rst_o, 1);
    chk("abrun_busy", busy_o, 0);
    tick();
    chk("abrun_still_idle", state_o, ST_IDLE);

    // async reset during LOAD after 3 words, while the third write is in flight
    for (int i = 0; i < 3; i++) prog[i] = 16'hC000 + 16'(i);
    start_load();
    load_prog(3, 1'b0, 0);
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    chk("mrst_rom_we", rom_we_o, 0);
    chk("mrst_cpu_rst", cpu_rst_o, 1);
    chk("mrst_word_count", word_count_o, 0);
    chk("mrst_ready", load_ready_o, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_rom_addr", rom_addr_o, 0);
    chk("mrst_rom_wdata", rom_wdata_o, 0);
    chk("mrst_run_cycles", run_cycles_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("mrst_state", state_o, ST_IDLE);

    // randomized programs and end loops
    for (int t = 0; t < 10; t++) begin
      int n, p, a, b;
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) prog[i] = 16'($urandom);
      p = $urandom_range(0, 6);
      for (int i = 0; i < p; i++) pc_arr[i] = $urandom_range(0, 40);
      a = $urandom_range(0, 40);
      b = ($urandom_range(0, 1) == 0) ? a : int'($urandom_range(0, 40));
      for (int j = 0; j < 12; j++) pc_arr[p + j] = (j % 2 == 0) ? a : b;
      start_load();
      load_prog(n, 1'b1, 2);
      run_and_halt(model_halt(p + 12), n);
    end

    tick();
    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_boot_ctrl.md
# hack_boot_ctrl

Boot and run sequencer for the Hack CPU. Holds the CPU in reset, accepts a program over a valid/ready stream, writes it into the instruction RAM, releases the CPU, and detects the end-of-program tight loop to freeze the CPU and flag completion. It sits between the host/loader interface and the CPU core plus its instruction memory.

## Interface

- DATA_WIDTH, 16, instruction/data word width
- ADDRESS_WIDTH, 16, instruction RAM address width
- ROM_DEPTH, 64, maximum program length in words
- RST_CYCLES, 2, cycles CPU reset stays high after load completes
- HALT_REPEAT, 4, consecutive loop matches that declare halt
- CYCLE_WIDTH, 32, run-cycle counter width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin load; honoured in IDLE, HALTED and ERROR only
- abort  in  1  return to IDLE from any state; wins over start
- load_valid  in  1  load word present
- load_ready  out  1  controller accepts word
- load_data  in  DATA_WIDTH  program word
- load_last  in  1  final word of program
- rom_we  out  1  instruction RAM write strobe
- rom_addr  out  ADDRESS_WIDTH  write address
- rom_wdata  out  DATA_WIDTH  write data
- cpu_rst  out  1  active-high reset to CPU core
- cpu_pc  in  ADDRESS_WIDTH  CPU program counter
- busy  out  1  state is LOAD, RELEASE or RUN
- done  out  1  state is HALTED
- error  out  1  state is ERROR
- word_count  out  ADDRESS_WIDTH  words accepted in current load
- run_cycles  out  CYCLE_WIDTH  cycles spent in RUN

## Operation

- States: IDLE, LOAD, RELEASE, RUN, HALTED, ERROR. Reset -> IDLE.
- Reset values: cpu_rst=1, all other outputs 0, internal counters and PC history 0.
- IDLE: cpu_rst=1, load_ready=0. start -> LOAD; word_count and run_cycles cleared on entry.
- LOAD: load_ready=1 (Moore). Handshake = load_valid & load_ready. Each handshake: capture load_data, rom_addr <= word_count, word_count += 1.
- Handshake with load_last=1 -> RELEASE. Handshake on word index ROM_DEPTH-1 with load_last=0 -> ERROR (word still written).
- RELEASE: cpu_rst=1 for RST_CYCLES cycles, then RUN.
- RUN: cpu_rst=0, run_cycles += 1 per cycle, saturating at all-ones. Halt detection active.
- Halt detection: record cpu_pc each RUN cycle into pc_d1, pc_d2. After two samples are valid, each cycle with cpu_pc == pc_d2 increments match count, else clears it. Match count == HALT_REPEAT -> HALTED. Covers both 1- and 2-instruction end loops.
- HALTED: cpu_rst=1, done=1, run_cycles and word_count held. start -> LOAD.
- ERROR: cpu_rst=1, error=1, load_ready=0. start -> LOAD.
- abort in any state -> IDLE next edge, cpu_rst=1, pending write still completes.
- start while busy ignored.

## Timing

- All outputs registered, except load_ready, busy, done and error, which decode state.
- Write latency: handshake at edge t -> rom_we=1 with rom_addr/rom_wdata valid in cycle after t, one cycle wide. Back-to-back handshakes give back-to-back writes, 1 word/cycle.
- Last handshake at edge t: state RELEASE after t, cpu_rst low after edge t+RST_CYCLES, first RUN cycle counts run_cycles=1.
- Halt: the edge on which match count reaches HALT_REPEAT also sets cpu_rst=1 and state HALTED.
- Async rst mid-load or mid-run: immediate return to reset values; no partial write strobe emitted after rst asserts.

## Structure

- hack_pkg: boot_state_t enum, default width constants shared with the CPU.
- Sub-module hack_halt_detect: PC history, valid tracking, match counter, halt pulse output; cleared whenever state is not RUN.

## Test plan

- Load 6 words 0x0002, 0xEC10, 0x0003, 0xE088, 0x0000, 0xE310 with load_valid held, last on word 6 -> rom_we pulses at addr 0..5 with matching data, word_count=6, cpu_rst low RST_CYCLES+1 cycles after last handshake.
- Drive cpu_pc 0,1,2,3,4,5,4,5,4,5... in RUN -> done=1 and cpu_rst=1 after HALT_REPEAT matches.
- load_valid toggled every other cycle -> writes only on handshake cycles, addresses contiguous with no gaps.
- 64 words without load_last -> 64 writes, error=1, load_ready=0; then start -> LOAD with word_count=0.
- abort and start asserted together in RUN at run_cycles=10 -> IDLE, cpu_rst=1, start ignored.
- rst asserted during LOAD after 3 words -> all outputs at reset values immediately, state IDLE after release.
